dbus_mem_ctrl: RTL and testbench

//  Data-bus memory controller between the core's dbus port and a handshaked memory.
//  The core issues a level request (req/we/addr/data/sel) and holds it while dbus_stall_o=1.
//  The controller turns each request into one valid/ready memory transaction, waits for the

---
 rtl/dbus_mem_ctrl_pkg.sv | 22 ++
 rtl/dbus_mem_ctrl_align_chk.sv | 22 ++
 rtl/dbus_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_dbus_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_mem_ctrl_pkg.sv
// Shared types and constants for the data-bus memory controller:
// FSM state encoding, default geometry/timeout and the byte-lane select patterns.
package dbus_mem_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF  = 32;
   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned TIMEOUT_DEF = 256;
   localparam int unsigned SEL_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_RSP,
      ST_DONE
   } state_e;

   localparam logic [SEL_W-1:0] SEL_WORD    = 4'b1111;
   localparam logic [SEL_W-1:0] SEL_HALF_LO = 4'b0011;
   localparam logic [SEL_W-1:0] SEL_HALF_HI = 4'b1100;
   localparam logic [SEL_W-1:0] SEL_BYTE    = 4'b0001;

endpackage

// File: rtl/dbus_mem_ctrl_align_chk.sv
// Combinational byte-lane alignment check: a select pattern is legal only at the
// low address bits that keep it inside one naturally aligned word/half/byte.
module dbus_align_chk
   import dbus_mem_ctrl_pkg::*;
(
   input  logic [SEL_W-1:0] sel_i,
   input  logic [1:0]       addr_lo_i,
   output logic             aligned_o
);

   always_comb begin
      // NOTE: default assignment first so every path drives aligned_o and no latch is inferred.
      aligned_o = 1'b0;
      case (sel_i)
         SEL_WORD:    aligned_o = (addr_lo_i == 2'd0);
         SEL_HALF_LO: aligned_o = (addr_lo_i == 2'd0);
         SEL_HALF_HI: aligned_o = (addr_lo_i == 2'd2);
         default:     aligned_o = (sel_i == (SEL_BYTE << addr_lo_i));
      endcase
   end

endmodule

// File: rtl/dbus_mem_ctrl.sv
// Data-bus memory controller: turns a held core request into one valid/ready memory
// transaction, waits for the response with a timeout and reports data/error in DONE.
module dbus_mem_ctrl
   import dbus_mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dbus_req_i,
   input  logic              dbus_we_i,
   input  logic [ADDR_W-1:0] dbus_addr_i,
   input  logic [DATA_W-1:0] dbus_data_i,
   input  logic [SEL_W-1:0]  dbus_sel_i,
   output logic [DATA_W-1:0] dbus_data_o,
   output logic              dbus_stall_o,
   output logic              dbus_err_o,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [SEL_W-1:0]  mem_wstrb_o,
   input  logic              mem_rsp_valid_i,
   input  logic [DATA_W-1:0] mem_rsp_data_i,
   input  logic              mem_rsp_err_i
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic                valid_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [SEL_W-1:0]    wstrb_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                aligned;
   logic                timeout_hit;

   dbus_align_chk u_align_chk (
      .sel_i     (dbus_sel_i),
      .addr_lo_i (dbus_addr_i[1:0]),
      .aligned_o (aligned)
   );

   always_comb begin
      cnt_d = cnt_q + 1'b1;
   end

   assign timeout_hit = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here sees pre-edge values.
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (dbus_req_i) begin
                  if (aligned) begin
                     we_q    <= dbus_we_i;
                     addr_q  <= {dbus_addr_i[ADDR_W-1:2], 2'b00};
                     wdata_q <= dbus_data_i;
                     wstrb_q <= dbus_we_i ? dbus_sel_i : '0;
                     valid_q <= 1'b1;
                     state_q <= ST_REQ;
                  end else begin
                     // Illegal lane pattern: report without touching memory.
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_REQ: begin
               if (mem_req_ready_i) begin
                  valid_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_WAIT_RSP;
               end
            end
            ST_WAIT_RSP: begin
               // A response in the timeout cycle takes priority over the abort.
               if (mem_rsp_valid_i) begin
                  rdata_q <= we_q ? '0 : mem_rsp_data_i;
                  err_q   <= mem_rsp_err_i;
                  state_q <= ST_DONE;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign dbus_stall_o    = dbus_req_i & (state_q != ST_DONE);
   assign dbus_data_o     = rdata_q;
   assign dbus_err_o      = err_q;
   assign mem_req_valid_o = valid_q;
   assign mem_we_o        = we_q;
   assign mem_addr_o      = addr_q;
   assign mem_wdata_o     = wdata_q;
   assign mem_wstrb_o     = wstrb_q;

endmodule

// File: tb/tb_dbus_mem_ctrl.sv
// Bench for dbus_mem_ctrl: a vector table drives core requests against a scripted memory,
// a scoreboard queue holds the expected DONE result of each request.
module tb_dbus_mem_ctrl;

   localparam int TMO = 8;
   localparam int NV  = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        dbus_req_i, dbus_we_i;
   logic [31:0] dbus_addr_i, dbus_data_i;
   logic [3:0]  dbus_sel_i;
   logic [31:0] dbus_data_o;
   logic        dbus_stall_o, dbus_err_o;
   logic        mem_req_valid_o, mem_req_ready_i, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        mem_rsp_valid_i, mem_rsp_err_i;
   logic [31:0] mem_rsp_data_i;

   always #5 clk = ~clk;

   dbus_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .dbus_req_i      (dbus_req_i),
      .dbus_we_i       (dbus_we_i),
      .dbus_addr_i     (dbus_addr_i),
      .dbus_data_i     (dbus_data_i),
      .dbus_sel_i      (dbus_sel_i),
      .dbus_data_o     (dbus_data_o),
      .dbus_stall_o    (dbus_stall_o),
      .dbus_err_o      (dbus_err_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_we_o        (mem_we_o),
      .mem_addr_o      (mem_addr_o),
      .mem_wdata_o     (mem_wdata_o),
      .mem_wstrb_o     (mem_wstrb_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_data_i  (mem_rsp_data_i),
      .mem_rsp_err_i   (mem_rsp_err_i)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          ready_dly;
      int          rsp_dly;
      bit          no_rsp;
      logic [31:0] rsp_data;
      logic        rsp_err;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_stall;
      bit          exp_mem;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] data;
      logic        err;
   } exp_t;

   vec_t vecs[NV+2];
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input int rdy, input int rspd, input bit no_rsp,
                          input logic [31:0] rdata, input logic rerr,
                          input logic [31:0] edata, input logic eerr,
                          input int estall, input bit emem);
      vecs[i].we = we;          vecs[i].addr = addr;       vecs[i].wdata = wdata;
      vecs[i].sel = sel;        vecs[i].ready_dly = rdy;   vecs[i].rsp_dly = rspd;
      vecs[i].no_rsp = no_rsp;  vecs[i].rsp_data = rdata;  vecs[i].rsp_err = rerr;
      vecs[i].exp_data = edata; vecs[i].exp_err = eerr;    vecs[i].exp_stall = estall;
      vecs[i].exp_mem = emem;
   endtask

   task automatic drive_idle();
      dbus_req_i      = 1'b0;
      dbus_we_i       = 1'b0;
      dbus_addr_i     = '0;
      dbus_data_i     = '0;
      dbus_sel_i      = '0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
      mem_rsp_err_i   = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, dbus_stall_o, 0);
      check({tag, "_err"},   dbus_err_o, 0);
      check({tag, "_data"},  dbus_data_o, 0);
      check({tag, "_valid"}, mem_req_valid_o, 0);
      check({tag, "_we"},    mem_we_o, 0);
      check({tag, "_addr"},  mem_addr_o, 0);
      check({tag, "_wdata"}, mem_wdata_o, 0);
      check({tag, "_wstrb"}, mem_wstrb_o, 0);
   endtask

   // One core request, with the bench playing the memory side cycle by cycle.
   task automatic run_txn(input vec_t v);
      int   valid_cnt, wait_cnt, stall_cnt, cyc;
      bit   accepted, done, saw_valid;
      exp_t e;
      valid_cnt = 0; wait_cnt = 0; stall_cnt = 0; cyc = 0;
      accepted = 0; done = 0; saw_valid = 0;
      e.we = v.we; e.data = v.exp_data; e.err = v.exp_err;
      sb_q.push_back(e);
      while (!done && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
         dbus_req_i  = 1'b1;
         dbus_we_i   = v.we;
         dbus_addr_i = v.addr;
         dbus_data_i = v.wdata;
         dbus_sel_i  = v.sel;
         mem_req_ready_i = 1'b0;
         mem_rsp_valid_i = 1'b0;
         mem_rsp_data_i  = '0;
         mem_rsp_err_i   = 1'b0;
         if (accepted) begin
            wait_cnt++;
            if (!v.no_rsp && wait_cnt == v.rsp_dly) begin
               mem_rsp_valid_i = 1'b1;
               mem_rsp_data_i  = v.rsp_data;
               mem_rsp_err_i   = v.rsp_err;
            end
         end
         if (mem_req_valid_o) begin
            saw_valid = 1;
            valid_cnt++;
            check("mem_addr",  mem_addr_o, {v.addr[31:2], 2'b00});
            check("mem_we",    mem_we_o, v.we);
            check("mem_wdata", mem_wdata_o, v.wdata);
            check("mem_wstrb", mem_wstrb_o, v.we ? v.sel : 4'b0000);
            if (valid_cnt == v.ready_dly + 1) begin
               mem_req_ready_i = 1'b1;
               accepted = 1;
            end
         end
         #1;
         if (dbus_stall_o) begin
            stall_cnt++;
         end else begin
            done = 1;
            e = sb_q.pop_front();
            check("done_err", dbus_err_o, e.err);
            if (!e.we) check("done_rdata", dbus_data_o, e.data);
            check("done_no_valid", mem_req_valid_o, 0);
         end
      end
      check("done_within_budget", done, 1);
      if (!done) sb_q.delete();
      check("stall_cycles", stall_cnt, v.exp_stall);
      check("mem_access", saw_valid, v.exp_mem);
      check("valid_cycles", valid_cnt, v.exp_mem ? v.ready_dly + 1 : 0);
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      drive_idle();
      #1;
      check("idle_err_pulse_ended", dbus_err_o, 0);
      check("idle_stall", dbus_stall_o, 0);
      check("idle_valid", mem_req_valid_o, 0);
   endtask

   // Late responses after a timeout must leave the controller idle.
   task automatic stray_rsp();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         drive_idle();
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = 32'hDEADBEEF;
         mem_rsp_err_i   = 1'b1;
         #1;
         check("stray_valid", mem_req_valid_o, 0);
         check("stray_err", dbus_err_o, 0);
      end
      @(posedge clk); #1;
      drive_idle();
      #1;
      check("stray_after_err", dbus_err_o, 0);
      check("stray_after_valid", mem_req_valid_o, 0);
   endtask

   task automatic reset_mid_wait();
      @(posedge clk); #1;
      drive_idle();
      dbus_req_i  = 1'b1;
      dbus_addr_i = 32'h80000070;
      dbus_sel_i  = 4'b1111;
      @(posedge clk); #1;
      check("rst_seq_valid", mem_req_valid_o, 1);
      mem_req_ready_i = 1'b1;
      @(posedge clk); #1;
      mem_req_ready_i = 1'b0;
      check("rst_seq_in_wait", mem_req_valid_o, 0);
      @(posedge clk); #1;
      rst        = 1'b1;
      dbus_req_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check_all_zero("rst_mid");
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_all_zero("reset");

      //       i  we    addr          wdata         sel      rdy rsp no  rsp_data      rerr exp_data      eerr stall mem
      set_vec(0, 1'b0, 32'h80000004, 32'h0,        4'b1111, 0,  1,  0, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 3,  1);
      set_vec(1, 1'b1, 32'h80000102, 32'hAABB0000, 4'b1100, 4,  1,  0, 32'h0,        1'b0, 32'h0,        1'b0, 7,  1);
      set_vec(2, 1'b0, 32'h80000001, 32'h0,        4'b0011, 0,  1,  0, 32'h0,        1'b0, 32'h0,        1'b1, 1,  0);
      set_vec(3, 1'b0, 32'h80000010, 32'h0,        4'b1111, 0,  1,  1, 32'h0,        1'b0, 32'h0,        1'b1, 10, 1);
      set_vec(4, 1'b0, 32'h80000022, 32'h0,        4'b0100, 1,  2,  0, 32'h55AA33CC, 1'b0, 32'h55AA33CC, 1'b0, 5,  1);
      set_vec(5, 1'b0, 32'h80000030, 32'h0,        4'b1111, 0,  TMO, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 10, 1);
      set_vec(6, 1'b1, 32'h80000040, 32'h12345678, 4'b0000, 0,  1,  0, 32'h0,        1'b0, 32'h0,        1'b1, 1,  0);
      set_vec(7, 1'b0, 32'h80000042, 32'h0,        4'b1111, 0,  1,  0, 32'h0,        1'b0, 32'h0,        1'b1, 1,  0);
      set_vec(8, 1'b1, 32'h00000008, 32'h0000BEEF, 4'b0011, 2,  1,  0, 32'h0,        1'b0, 32'h0,        1'b0, 5,  1);
      set_vec(9, 1'b0, 32'h80000063, 32'h0,        4'b1000, 0,  3,  0, 32'h11112222, 1'b1, 32'h11112222, 1'b1, 5,  1);
      set_vec(10, 1'b0, 32'h80000080, 32'h0,       4'b1111, 0,  1,  0, 32'hA5A50001, 1'b0, 32'hA5A50001, 1'b0, 3,  1);
      set_vec(11, 1'b0, 32'h80000085, 32'h0,       4'b0010, 1,  1,  0, 32'h00003C00, 1'b0, 32'h00003C00, 1'b0, 4,  1);

      for (int i = 0; i < NV; i++) begin
         run_txn(vecs[i]);
         idle_cycle();
         if (i == 3) stray_rsp();
      end

      reset_mid_wait();
      run_txn(vecs[10]);
      run_txn(vecs[11]);
      idle_cycle();

      check("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
